// File: rtl/boton_pulso_gen.sv
// boton_pulso_gen
//   Front end for the button-driven sequencer. It synchronizes and debounces
//   a raw push-button, then emits clean one-cycle press pulses. While the
//   button is held, it can also emit auto-repeat pulses.
//
// Parameters:
//   DEB_CYCLES - consecutive synchronized samples needed to accept a level change
//   REP_EN     - 1 enables auto-repeat while the button is held
//   REP_DELAY  - cycles from the press pulse to the first repeat pulse
//   REP_RATE   - cycles between subsequent repeat pulses
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   boton_raw - raw button level; asynchronous to clk and may bounce
//   pulso     - one-cycle pulse per accepted press or repeat
//   estable   - debounced button level
//   cuenta    - number of pulso assertions, modulo 8
module boton_pulso_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int REP_EN     = 1,
  parameter int REP_DELAY  = 16,
  parameter int REP_RATE   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_raw,
  output logic       pulso,
  output logic       estable,
  output logic [2:0] cuenta
);

  localparam int CMAX = (DEB_CYCLES > REP_DELAY) ? DEB_CYCLES : REP_DELAY;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] REP_MAX   = CW'(REP_DELAY);
  // The hold timer is reloaded here after a repeat, so the next repeat
  // arrives REP_RATE cycles later. If REP_RATE exceeds REP_DELAY, the reload
  // value is clamped to zero.
  localparam logic [CW-1:0] REP_RELOAD =
    (REP_RATE >= REP_DELAY) ? '0 : CW'(REP_DELAY - REP_RATE);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  logic          s1, s2;
  state_t        state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic          pulso_q, pulso_d;
  logic          estable_q, estable_d;
  logic [2:0]    cuenta_q, cuenta_d;

  // Two-flop synchronizer. Only s2 is used by the rest of the design.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= boton_raw;
      s2 <= s1;
    end
  end

  // State register. All outputs are taken directly from registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      pulso_q   <= 1'b0;
      estable_q <= 1'b0;
      cuenta_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      pulso_q   <= pulso_d;
      estable_q <= estable_d;
      cuenta_q  <= cuenta_d;
    end
  end

  // Next-state logic for the debounce and repeat FSM.
  // A repeat is suppressed if pulso is already high, so pulso can never be
  // high for two consecutive cycles, even when REP_DELAY is 1.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    hcnt_d    = hcnt_q;
    pulso_d   = 1'b0;
    estable_d = estable_q;
    cuenta_d  = cuenta_q;

    case (state_q)
      IDLE: begin
        if (s2) begin
          if (DEB_CYCLES == 1) begin
            state_d   = PRESSED;
            estable_d = 1'b1;
            pulso_d   = 1'b1;
            hcnt_d    = '0;
            dcnt_d    = '0;
          end else begin
            state_d = DEB_PRESS;
            dcnt_d  = CW'(1);
          end
        end
      end

      DEB_PRESS: begin
        if (!s2) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DEB_LAST) begin
          state_d   = PRESSED;
          estable_d = 1'b1;
          pulso_d   = 1'b1;
          hcnt_d    = '0;
          dcnt_d    = '0;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end

      PRESSED: begin
        if (!s2) begin
          if (DEB_CYCLES == 1) begin
            state_d   = IDLE;
            estable_d = 1'b0;
            dcnt_d    = '0;
          end else begin
            state_d = DEB_RELEASE;
            dcnt_d  = CW'(1);
          end
        end else if (REP_EN != 0) begin
          if (hcnt_q == REP_LAST) begin
            hcnt_d  = REP_RELOAD;
            pulso_d = !pulso_q;
          end else begin
            hcnt_d = hcnt_q + CW'(1);
          end
        end else if (hcnt_q != REP_MAX) begin
          hcnt_d = hcnt_q + CW'(1);
        end
      end

      DEB_RELEASE: begin
        if (s2) begin
          state_d = PRESSED;
          hcnt_d  = '0;
          dcnt_d  = '0;
        end else if (dcnt_q == DEB_LAST) begin
          state_d   = IDLE;
          estable_d = 1'b0;
          dcnt_d    = '0;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (pulso_d) begin
      cuenta_d = cuenta_q + 3'd1;
    end
  end

  assign pulso   = pulso_q;
  assign estable = estable_q;
  assign cuenta  = cuenta_q;

endmodule

// File: tb/tb_boton_pulso_gen.sv
// tb_boton_pulso_gen
//   Directed bench for boton_pulso_gen. It uses two instances that share the
//   same stimulus: one with auto-repeat enabled and one with it disabled.
//   Inputs change 1 time unit after a rising edge, and outputs are sampled at
//   the same point. Edge numbering therefore starts at the first rising edge
//   that sees the new raw level.
module tb_boton_pulso_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       boton_raw = 1'b0;
  logic       pulso, estable;
  logic [2:0] cuenta;
  logic       pulso_nr, estable_nr;
  logic [2:0] cuenta_nr;

  int vectors = 0;
  int miscompares = 0;

  boton_pulso_gen #(.DEB_CYCLES(4), .REP_EN(1), .REP_DELAY(16), .REP_RATE(8)) dut (
    .clk(clk), .reset(reset), .boton_raw(boton_raw),
    .pulso(pulso), .estable(estable), .cuenta(cuenta)
  );

  boton_pulso_gen #(.DEB_CYCLES(4), .REP_EN(0), .REP_DELAY(16), .REP_RATE(8)) dut_nr (
    .clk(clk), .reset(reset), .boton_raw(boton_raw),
    .pulso(pulso_nr), .estable(estable_nr), .cuenta(cuenta_nr)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then step clear of it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    boton_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({pulso, estable, cuenta} !== 5'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_hold cyc %0d got=%b exp=%b", i, {pulso, estable, cuenta}, 5'b0);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if ({pulso, estable, cuenta, pulso_nr, estable_nr, cuenta_nr} !== 10'b0) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cyc %0d got=%b exp=%b", i,
                 {pulso, estable, cuenta, pulso_nr, estable_nr, cuenta_nr}, 10'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [1:0] exp_v;
    boton_raw = 1'b0;
    do_reset();
    boton_raw = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      exp_v = {(k == 5), (k >= 5)};
      vectors++;
      if ({pulso, estable} !== exp_v || {pulso_nr, estable_nr} !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL clean_press edge %0d got=%b/%b exp=%b", k,
                 {pulso, estable}, {pulso_nr, estable_nr}, exp_v);
      end
    end
    boton_raw = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      exp_v = {1'b0, (j < 5)};
      vectors++;
      if ({pulso, estable} !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL clean_release step %0d got=%b exp=%b", j, {pulso, estable}, exp_v);
      end
    end
    vectors++;
    if (cuenta !== 3'd1 || cuenta_nr !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL clean_cuenta got=%0d/%0d exp=1", cuenta, cuenta_nr);
    end
  endtask

  task automatic test_bounce();
    boton_raw = 1'b0;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      boton_raw = (k < 8) && (k % 2 == 0);
      step();
      vectors++;
      if ({pulso, estable} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL bounce edge %0d got=%b exp=00", k, {pulso, estable});
      end
    end
    vectors++;
    if (cuenta !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL bounce_cuenta got=%0d exp=0", cuenta);
    end
  endtask

  task automatic test_auto_repeat();
    logic exp_p;
    boton_raw = 1'b0;
    do_reset();
    boton_raw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      exp_p = (k == 5) || (k == 21) || (k == 29) || (k == 37);
      vectors++;
      if (pulso !== exp_p || pulso_nr !== (k == 5) || estable !== (k >= 5)) begin
        miscompares++;
        $display("[TB] FAIL auto_repeat edge %0d got p=%b pnr=%b e=%b exp p=%b pnr=%b e=%b",
                 k, pulso, pulso_nr, estable, exp_p, (k == 5), (k >= 5));
      end
    end
    boton_raw = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      vectors++;
      if (pulso !== 1'b0 || pulso_nr !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL repeat_release step %0d got=%b%b exp=00", j, pulso, pulso_nr);
      end
    end
    vectors++;
    if (cuenta !== 3'd4 || cuenta_nr !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL repeat_cuenta got=%0d/%0d exp=4/1", cuenta, cuenta_nr);
    end
  endtask

  task automatic test_release_glitch();
    boton_raw = 1'b0;
    do_reset();
    for (int k = 0; k < 31; k++) begin
      boton_raw = !((k == 8) || (k == 9));
      step();
      vectors++;
      if (pulso !== ((k == 5) || (k == 28)) || pulso_nr !== (k == 5) ||
          estable !== (k >= 5) || estable_nr !== (k >= 5)) begin
        miscompares++;
        $display("[TB] FAIL release_glitch edge %0d got p=%b pnr=%b e=%b enr=%b",
                 k, pulso, pulso_nr, estable, estable_nr);
      end
    end
    boton_raw = 1'b0;
    repeat (10) step();
    vectors++;
    if (cuenta !== 3'd2 || cuenta_nr !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL glitch_cuenta got=%0d/%0d exp=2/1", cuenta, cuenta_nr);
    end
  endtask

  task automatic test_wrap();
    int pulses;
    boton_raw = 1'b0;
    do_reset();
    for (int p = 0; p < 9; p++) begin
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
        boton_raw = (k < 8);
        step();
        pulses += int'(pulso);
      end
      vectors++;
      if (pulses != 1 || cuenta !== 3'((p + 1) % 8) || cuenta_nr !== 3'((p + 1) % 8)) begin
        miscompares++;
        $display("[TB] FAIL wrap press %0d got pulses=%0d cuenta=%0d/%0d exp pulses=1 cuenta=%0d",
                 p, pulses, cuenta, cuenta_nr, (p + 1) % 8);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    boton_raw = 1'b1;
    for (int k = 0; k < 6; k++) step();
    vectors++;
    if (pulso !== 1'b1 || cuenta !== 3'd2) begin
      miscompares++;
      $display("[TB] FAIL midhold_pre got p=%b cuenta=%0d exp p=1 cuenta=2", pulso, cuenta);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({pulso, estable, cuenta} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL midhold_async got=%b exp=%b", {pulso, estable, cuenta}, 5'b0);
    end
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      vectors++;
      if (pulso !== (k == 5) || estable !== (k >= 5)) begin
        miscompares++;
        $display("[TB] FAIL midhold_repress edge %0d got p=%b e=%b exp p=%b e=%b",
                 k, pulso, estable, (k == 5), (k >= 5));
      end
    end
    vectors++;
    if (cuenta !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL midhold_cuenta got=%0d exp=1", cuenta);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_release_glitch();
    test_wrap();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
